// File: rtl/dcache_pkg.sv
// Shared types and field geometry for the direct-mapped data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      ALLOCATE  = 2'd3
   } state_t;

   localparam int LINE_W    = 128;
   localparam int WORD_W    = 32;
   localparam int OFFSET_W  = 2;
   localparam int BLOCK_OFF = 4;
   localparam int WORD_LSB  = BLOCK_OFF - OFFSET_W;

endpackage

// File: rtl/data_cache_controller_if.sv
// CPU data-port handshake: the pipeline is master, the cache responds.
interface data_cache_controller_if #(
   parameter int ADDR_W = 32
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              busywait;

   modport master (output read, write, address, writedata, input readdata, busywait);
   modport slave  (input read, write, address, writedata, output readdata, busywait);
endinterface

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage; valid and dirty reset, tag and data do not.
module dcache_line_array
   import dcache_pkg::*;
#(
   parameter int LINES   = 8,
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 25
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [INDEX_W-1:0]  index,
   input  logic                word_we,
   input  logic [OFFSET_W-1:0] word_sel,
   input  logic [WORD_W-1:0]   word_data,
   input  logic                line_we,
   input  logic [TAG_W-1:0]    line_tag,
   input  logic [LINE_W-1:0]   line_data,
   output logic                rd_valid,
   output logic                rd_dirty,
   output logic [TAG_W-1:0]    rd_tag,
   output logic [LINE_W-1:0]   rd_line
);

   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  dirty_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINE_W-1:0] data_q [LINES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (word_we) begin
         dirty_q[index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_q[index]  <= line_tag;
         data_q[index] <= line_data;
      end else if (word_we) begin
         data_q[index][word_sel*WORD_W +: WORD_W] <= word_data;
      end
   end

   assign rd_valid = valid_q[index];
   assign rd_dirty = dirty_q[index];
   assign rd_tag   = tag_q[index];
   assign rd_line  = data_q[index];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped write-back/write-allocate data cache: hit compare, miss FSM, memory drivers.
//   state     | meaning
//   IDLE      | serve hits; classify a miss as clean (FETCH) or dirty (WRITEBACK)
//   WRITEBACK | evict dirty line to memory
//   FETCH     | read requested block from memory
//   ALLOCATE  | install fetched block, tag, valid=1, dirty=0
module data_cache_controller
   import dcache_pkg::*;
#(
   parameter int LINES  = 8,
   parameter int ADDR_W = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   data_cache_controller_if.slave      cpu,
   output logic                        mem_read,
   output logic                        mem_write,
   output logic [ADDR_W-BLOCK_OFF-1:0] mem_address,
   output logic [LINE_W-1:0]           mem_writedata,
   input  logic [LINE_W-1:0]           mem_readdata,
   input  logic                        mem_busywait
);

   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = ADDR_W - BLOCK_OFF - INDEX_W;

   state_t              state_q, state_d;
   logic                settled_q;
   logic [INDEX_W-1:0]  index;
   logic [TAG_W-1:0]    tag;
   logic [OFFSET_W-1:0] word_sel;
   logic                rd_valid, rd_dirty;
   logic [TAG_W-1:0]    rd_tag;
   logic [LINE_W-1:0]   rd_line;
   logic                hit, req, word_we, line_we;
   logic                unused_addr_lsb;

   assign index           = cpu.address[BLOCK_OFF +: INDEX_W];
   assign tag             = cpu.address[ADDR_W-1 -: TAG_W];
   assign word_sel        = cpu.address[WORD_LSB +: OFFSET_W];
   assign unused_addr_lsb = &{1'b0, cpu.address[WORD_LSB-1:0]};

   assign hit = rd_valid && (rd_tag == tag);
   assign req = cpu.read || cpu.write;

   // Outputs are gated by reset so the CPU sees an idle port while reset is held.
   assign cpu.busywait = reset && req && !(state_q == IDLE && hit);
   assign cpu.readdata = (reset && cpu.read) ? rd_line[word_sel*WORD_W +: WORD_W] : '0;

   dcache_line_array #(
      .LINES   (LINES),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_lines (
      .clk       (clk),
      .reset     (reset),
      .index     (index),
      .word_we   (word_we),
      .word_sel  (word_sel),
      .word_data (cpu.writedata),
      .line_we   (line_we),
      .line_tag  (tag),
      .line_data (mem_readdata),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line)
   );

   // settled_q marks the second and later cycles of a state, so memory has had
   // a cycle to raise mem_busywait before its low level is taken as "done".
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         settled_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         settled_q <= (state_d == state_q);
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      word_we       = 1'b0;
      line_we       = 1'b0;
      case (state_q)
         IDLE: begin
            word_we = cpu.write && hit;
            if (req && !hit)
               state_d = rd_dirty ? WRITEBACK : FETCH;
         end
         WRITEBACK: begin
            mem_write     = 1'b1;
            mem_address   = {rd_tag, index};
            mem_writedata = rd_line;
            if (settled_q && !mem_busywait)
               state_d = FETCH;
         end
         FETCH: begin
            mem_read    = 1'b1;
            mem_address = cpu.address[ADDR_W-1:BLOCK_OFF];
            if (settled_q && !mem_busywait)
               state_d = ALLOCATE;
         end
         ALLOCATE: begin
            line_we = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
